// File: rtl/clock_pkg.sv
// Shared desk-clock timing constants and the strobe bundle type used by
// refclk_strobe_gen.
package clock_pkg;

  localparam int unsigned REFCLK_HZ   = 32768;
  localparam int unsigned SLOW_SET_HZ = 2;
  localparam int unsigned FAST_SET_HZ = 8;
  localparam int unsigned DEBOUNCE_HZ = 1024;

  // Each divider is the number of refclk rising edges per strobe.
  localparam int unsigned DEF_REFCLK_DIV   = REFCLK_HZ;
  localparam int unsigned DEF_SLOW_SET_DIV = REFCLK_HZ / SLOW_SET_HZ;
  localparam int unsigned DEF_FAST_SET_DIV = REFCLK_HZ / FAST_SET_HZ;
  localparam int unsigned DEF_DEBOUNCE_DIV = REFCLK_HZ / DEBOUNCE_HZ;

  typedef struct packed {
    logic hz1;
    logic slow_set;
    logic fast_set;
    logic debounce;
  } strobe_t;

endpackage

// File: rtl/refclk_edge_sync.sv
// Brings the asynchronous refclk into the clk domain and flags each rising edge.
// Build macro REFCLK_SYNC_3FF_EN selects a three-flop synchronizer (default two).
module refclk_edge_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_refclk,
  output logic o_refclk_sync,
  output logic o_edge
);

`ifdef REFCLK_SYNC_3FF_EN
  localparam int unsigned STAGES = 3;
`else
  localparam int unsigned STAGES = 2;
`endif

  logic [STAGES-1:0] sync_q;
  logic              hist_q;
  logic              edge_q;
  logic              edge_d;

  assign edge_d = sync_q[STAGES-1] & ~hist_q;

  // The edge flag is registered so the strobe path is sync, edge, output stage.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_refclk};
      hist_q <= sync_q[STAGES-1];
      edge_q <= edge_d;
    end
  end

  assign o_refclk_sync = sync_q[STAGES-1];
  assign o_edge        = edge_q;

endmodule

// File: rtl/refclk_strobe_gen.sv
// Counts synchronized refclk rising edges and decodes nested one-cycle strobes.
// Build macro REFCLK_SYNC_3FF_EN adds a third synchronizer stage (one more cycle of latency).
module refclk_strobe_gen
  import clock_pkg::*;
#(
  parameter int unsigned REFCLK_DIV   = DEF_REFCLK_DIV,
  parameter int unsigned SLOW_SET_DIV = DEF_SLOW_SET_DIV,
  parameter int unsigned FAST_SET_DIV = DEF_FAST_SET_DIV,
  parameter int unsigned DEBOUNCE_DIV = DEF_DEBOUNCE_DIV
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_refclk,
  output logic o_refclk_sync,
  output logic o_1hz_stb,
  output logic o_slow_set_stb,
  output logic o_fast_set_stb,
  output logic o_debounce_stb
);

  localparam int unsigned CNT_W = $clog2(REFCLK_DIV);

  // Low-bit masks: a strobe fires when its low bits are all ones before the increment.
  localparam logic [CNT_W-1:0] HZ1_MASK  = CNT_W'(REFCLK_DIV - 1);
  localparam logic [CNT_W-1:0] SLOW_MASK = CNT_W'(SLOW_SET_DIV - 1);
  localparam logic [CNT_W-1:0] FAST_MASK = CNT_W'(FAST_SET_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_MASK  = CNT_W'(DEBOUNCE_DIV - 1);

  logic             edge_w;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  strobe_t          stb_q;
  strobe_t          stb_d;

  refclk_edge_sync u_edge_sync (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_refclk      (i_refclk),
    .o_refclk_sync (o_refclk_sync),
    .o_edge        (edge_w)
  );

  always_comb begin
    cnt_d = cnt_q;
    stb_d = '0;
    if (edge_w) begin
      cnt_d          = cnt_q + CNT_W'(1);
      stb_d.hz1      = (cnt_q & HZ1_MASK)  == HZ1_MASK;
      stb_d.slow_set = (cnt_q & SLOW_MASK) == SLOW_MASK;
      stb_d.fast_set = (cnt_q & FAST_MASK) == FAST_MASK;
      stb_d.debounce = (cnt_q & DEB_MASK)  == DEB_MASK;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
      stb_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      stb_q <= stb_d;
    end
  end

  assign o_1hz_stb      = stb_q.hz1;
  assign o_slow_set_stb = stb_q.slow_set;
  assign o_fast_set_stb = stb_q.fast_set;
  assign o_debounce_stb = stb_q.debounce;

endmodule

// File: tb/tb_refclk_strobe_gen.sv
// Self-checking bench for refclk_strobe_gen: three instances (16/8/4/2, 2/2/2/2, defaults)
// share one refclk and are checked each cycle against an edge-event model.
module tb_refclk_strobe_gen;

`ifdef REFCLK_SYNC_3FF_EN
  localparam int SYNC = 3;
`else
  localparam int SYNC = 2;
`endif
  localparam int LAT = SYNC + 2;
  localparam int NI  = 3;

  // Divider per instance g and strobe s (0=1hz, 1=slow, 2=fast, 3=debounce).
  function automatic int div_of(int g, int s);
    if (g == 0) return 16 >> s;
    if (g == 1) return 2;
    case (s)
      0:       return 32768;
      1:       return 16384;
      2:       return 4096;
      default: return 32;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic refclk = 1'b0;
  logic [NI-1:0] sync_o, hz1_o, slow_o, fast_o, deb_o;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    refclk_strobe_gen #(
      .REFCLK_DIV   (div_of(g, 0)),
      .SLOW_SET_DIV (div_of(g, 1)),
      .FAST_SET_DIV (div_of(g, 2)),
      .DEBOUNCE_DIV (div_of(g, 3))
    ) u_dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_refclk       (refclk),
      .o_refclk_sync  (sync_o[g]),
      .o_1hz_stb      (hz1_o[g]),
      .o_slow_set_stb (slow_o[g]),
      .o_fast_set_stb (fast_o[g]),
      .o_debounce_stb (deb_o[g])
    );
  end

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   since_rel = 0;
  logic lvl [8];
  int   due_q [$];
  int   k = 0;
  int   seen [NI][4];

  always @(posedge clk) begin
    cyc++;
    lvl[cyc % 8] = refclk;
    since_rel = rst ? 0 : since_rel + 1;
  end

  // Model: every counted refclk rising edge becomes a strobe event LAT edges later;
  // event number k fires strobe s whenever k is a multiple of that divider.
  always @(negedge clk) begin
    logic       fire;
    logic       exp_sync;
    logic [3:0] exp_stb;
    logic [3:0] got_stb;
    fire = 1'b0;
    if (!rst && due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      k++;
      fire = 1'b1;
    end
    exp_sync = (!rst && since_rel >= SYNC) ? lvl[(cyc - SYNC + 1) % 8] : 1'b0;
    for (int g = 0; g < NI; g++) begin
      for (int s = 0; s < 4; s++) exp_stb[3-s] = fire && (k % div_of(g, s) == 0);
      got_stb = {hz1_o[g], slow_o[g], fast_o[g], deb_o[g]};
      n_vec++;
      if ({sync_o[g], got_stb} !== {exp_sync, exp_stb}) begin
        n_err++;
        $display("FAIL cycle_check cyc=%0d dut%0d {sync,1hz,slow,fast,deb} got %b_%b want %b_%b",
                 cyc, g, sync_o[g], got_stb, exp_sync, exp_stb);
      end
      for (int s = 0; s < 4; s++) if (got_stb[3-s] === 1'b1) seen[g][s]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_ref(input logic v);
    if (v && !refclk && !rst) due_q.push_back(cyc + LAT);
    refclk = v;
  endtask

  task automatic pulse(input int hi, input int lo);
    set_ref(1'b1);
    tick(hi);
    set_ref(1'b0);
    tick(lo);
  endtask

  // A high refclk at release counts as one rising edge.
  task automatic do_reset(input logic ref_at_release);
    rst = 1'b1;
    due_q.delete();
    k = 0;
    tick(3);
    refclk = ref_at_release;
    tick(1);
    rst = 1'b0;
    if (ref_at_release) due_q.push_back(cyc + LAT);
  endtask

  task automatic clear_seen();
    for (int g = 0; g < NI; g++)
      for (int s = 0; s < 4; s++) seen[g][s] = 0;
  endtask

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
  endtask

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog got timeout want completion");
    summary();
    $finish;
  end

  initial begin
    int t0;
    int n;
    clear_seen();
    #1 rst = 1'b1;

    // Refclk toggling during reset is invisible.
    tick(2);
    refclk = 1'b1;
    tick(3);
    check("reset_sync", int'(sync_o[0]), 0);
    refclk = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(100);
    check("idle_1hz",  seen[0][0], 0);
    check("idle_deb",  seen[0][3], 0);
    check("idle_bdeb", seen[1][3], 0);

    // Synchronizer latency.
    t0 = cyc;
    set_ref(1'b1);
    n = 0;
    while (sync_o[0] !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    check("sync_latency", cyc - t0, SYNC);
    tick(10);
    set_ref(1'b0);
    tick(10);

    // Second edge on the DIV=2 instance gives its 1 Hz strobe.
    t0 = cyc;
    set_ref(1'b1);
    n = 0;
    while (hz1_o[1] !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    check("hz1_latency", cyc - t0, LAT);
    tick(1);
    check("hz1_width", int'(hz1_o[1]), 0);
    tick(10);
    set_ref(1'b0);
    tick(10);
    check("model_k_latency", k, 2);

    // Periods over 64 edges, refclk period 20.
    do_reset(1'b0);
    tick(5);
    clear_seen();
    repeat (64) pulse(10, 10);
    check("period_1hz",  seen[0][0], 4);
    check("period_slow", seen[0][1], 8);
    check("period_fast", seen[0][2], 16);
    check("period_deb",  seen[0][3], 32);
    check("period_b1hz", seen[1][0], 32);
    check("model_k_period", k, 64);

    // Reset after 10 edges: a full 16 edges are needed again.
    do_reset(1'b0);
    tick(5);
    repeat (10) pulse(10, 10);
    do_reset(1'b0);
    tick(5);
    clear_seen();
    repeat (15) pulse(10, 10);
    check("midrst_15_1hz", seen[0][0], 0);
    pulse(10, 10);
    check("midrst_16_1hz", seen[0][0], 1);

    // Release with refclk stuck high: exactly one counted edge.
    clear_seen();
    do_reset(1'b1);
    tick(60);
    check("stuck_hi_deb", seen[0][3], 0);
    check("stuck_hi_sync", int'(sync_o[0]), 1);
    set_ref(1'b0);
    tick(10);
    set_ref(1'b1);
    tick(20);
    check("stuck_hi_next_deb", seen[0][3], 1);
    set_ref(1'b0);
    tick(10);

    // Default dividers: refclk toggled every clk to keep the run short.
    do_reset(1'b0);
    tick(5);
    clear_seen();
    repeat (32767) begin
      set_ref(1'b1);
      tick(1);
      set_ref(1'b0);
      tick(1);
    end
    tick(10);
    check("def_pre_1hz",  seen[2][0], 0);
    check("def_pre_slow", seen[2][1], 1);
    check("def_pre_fast", seen[2][2], 7);
    check("def_pre_deb",  seen[2][3], 1023);
    set_ref(1'b1);
    tick(1);
    set_ref(1'b0);
    tick(10);
    check("def_1hz",  seen[2][0], 1);
    check("def_slow", seen[2][1], 2);
    check("def_fast", seen[2][2], 8);
    check("def_deb",  seen[2][3], 1024);
    check("def_model_k", k, 32768);

    summary();
    $finish;
  end

endmodule
